// File: rtl/chord_voice_scheduler.sv
// chord_voice_scheduler
//   Time-shares one sine ROM among three voices. Each sample_tick starts a
//   sweep IDLE -> V0 -> V1 -> V2 -> DONE. During the sweep every voice reads
//   its level, adds it to the accumulator and advances its phase. The sum of
//   the enabled voices is presented on sample_out with a one-cycle
//   sample_valid strobe.
//
// Ports
//   clock, reset       single clock domain, asynchronous active-high reset
//   sample_tick        one-cycle pulse at the audio sample rate
//   voice_en[2:0]      per-voice enable, latched at sweep start
//   freq_id0..2        per-voice tone ids, latched at sweep start
//   rom_index          registered ROM address {1'b0, phase[15:6]}
//   rom_freq_id        registered ROM tone id
//   rom_level          ROM level, combinational from rom_index
//   rom_freq           ROM phase increment, combinational from rom_freq_id
//   sample_out         registered sum of enabled voice levels
//   sample_valid       one-cycle strobe while sample_out holds a new sum
//   busy               high in every state except IDLE
//   tick_overrun       one-cycle pulse when a tick arrives mid-sweep
module chord_voice_scheduler #(
  parameter int BITS = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [2:0]        voice_en,
  input  logic [4:0]        freq_id0,
  input  logic [4:0]        freq_id1,
  input  logic [4:0]        freq_id2,
  output logic [10:0]       rom_index,
  output logic [4:0]        rom_freq_id,
  input  logic [BITS-1:0]   rom_level,
  input  logic [15:0]       rom_freq,
  output logic [BITS+1:0]   sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              tick_overrun
);

  typedef enum logic [2:0] {IDLE, V0, V1, V2, DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              sweep_start;
  logic [2:0]        voice_hit;     // one-hot: voice whose ROM data is on the bus

  logic [2:0]        en_reg;
  logic [2:0][4:0]   fid_reg;
  logic [BITS+1:0]   acc_reg;
  logic [BITS+1:0]   acc_next;
  logic [BITS+1:0]   level_ext;
  logic              voice_on;

  logic [2:0][9:0]   phase_top;     // phase[15:6] of every voice
  logic [10:0]       rom_index_next;
  logic [4:0]        rom_freq_id_next;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and per-state decode
  always_comb begin
    state_next  = state_reg;
    sweep_start = 1'b0;
    voice_hit   = 3'b000;
    case (state_reg)
      IDLE: begin
        if (sample_tick) begin
          state_next  = V0;
          sweep_start = 1'b1;
        end
      end
      V0: begin
        state_next = V1;
        voice_hit  = 3'b001;
      end
      V1: begin
        state_next = V2;
        voice_hit  = 3'b010;
      end
      V2: begin
        state_next = DONE;
        voice_hit  = 3'b100;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign voice_on  = |(en_reg & voice_hit);
  assign level_ext = {2'b00, rom_level};
  assign acc_next  = voice_on ? (acc_reg + level_ext) : acc_reg;

  // Per-voice phase accumulators. A disabled voice is held at zero so it
  // restarts at a zero crossing when it is enabled again.
  for (genvar gi = 0; gi < 3; gi++) begin : g_voice
    logic [15:0] phase_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        phase_reg <= '0;
      end else if (voice_hit[gi]) begin
        phase_reg <= en_reg[gi] ? (phase_reg + rom_freq) : 16'd0;
      end
    end

    assign phase_top[gi] = phase_reg[15:6];
  end

  // ROM address for the voice served in the next cycle. Voice 0 is loaded
  // from the live freq_id0 on the starting edge because the shadow copy is
  // written on that same edge. After voice 2 the ROM is parked on voice 0.
  always_comb begin
    rom_index_next   = rom_index;
    rom_freq_id_next = rom_freq_id;
    if (sweep_start) begin
      rom_index_next   = {1'b0, phase_top[0]};
      rom_freq_id_next = freq_id0;
    end else if (voice_hit[0]) begin
      rom_index_next   = {1'b0, phase_top[1]};
      rom_freq_id_next = fid_reg[1];
    end else if (voice_hit[1]) begin
      rom_index_next   = {1'b0, phase_top[2]};
      rom_freq_id_next = fid_reg[2];
    end else if (voice_hit[2]) begin
      rom_index_next   = {1'b0, phase_top[0]};
      rom_freq_id_next = fid_reg[0];
    end
  end

  // Shadows, accumulator, ROM drive and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_reg       <= '0;
      fid_reg      <= '0;
      acc_reg      <= '0;
      rom_index    <= '0;
      rom_freq_id  <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      if (sweep_start) begin
        en_reg  <= voice_en;
        fid_reg <= {freq_id2, freq_id1, freq_id0};
        acc_reg <= '0;
      end else if (|voice_hit) begin
        acc_reg <= acc_next;
      end

      rom_index   <= rom_index_next;
      rom_freq_id <= rom_freq_id_next;

      // The final sum is captured on the V2 -> DONE edge so sample_out and
      // sample_valid are both presented during the DONE cycle.
      sample_valid <= voice_hit[2];
      if (voice_hit[2]) begin
        sample_out <= acc_next;
      end

      tick_overrun <= sample_tick & busy;
    end
  end

endmodule

// File: tb/tb_chord_voice_scheduler.sv
// tb_chord_voice_scheduler
//   Directed bench for chord_voice_scheduler (BITS=6). A small ROM model
//   drives rom_level/rom_freq. The driver pushes the hand-computed sample
//   for every tick into a scoreboard queue; a monitor pops and compares on
//   each sample_valid, also checking the tick-to-valid latency.
module tb_chord_voice_scheduler;

  localparam int BITS = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            sample_tick = 1'b0;
  logic [2:0]      voice_en = 3'b000;
  logic [4:0]      freq_id0 = 5'd0;
  logic [4:0]      freq_id1 = 5'd0;
  logic [4:0]      freq_id2 = 5'd0;
  logic [10:0]     rom_index;
  logic [4:0]      rom_freq_id;
  logic [BITS-1:0] rom_level;
  logic [15:0]     rom_freq;
  logic [BITS+1:0] sample_out;
  logic            sample_valid;
  logic            busy;
  logic            tick_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_count = 0;
  int overrun_count = 0;
  int expected_valids = 0;

  typedef struct {
    int value;
    int edge_cyc;
  } exp_t;

  exp_t sb[$];

  chord_voice_scheduler #(.BITS(BITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .voice_en     (voice_en),
    .freq_id0     (freq_id0),
    .freq_id1     (freq_id1),
    .freq_id2     (freq_id2),
    .rom_index    (rom_index),
    .rom_freq_id  (rom_freq_id),
    .rom_level    (rom_level),
    .rom_freq     (rom_freq),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ROM model: a few pinned points, otherwise level = index[5:0].
  function automatic logic [5:0] rom_level_fn(input logic [10:0] idx);
    case (idx)
      11'd113: rom_level_fn = 6'd30;
      11'd100: rom_level_fn = 6'd27;
      default: rom_level_fn = idx[5:0];
    endcase
  endfunction

  function automatic logic [15:0] rom_freq_fn(input logic [4:0] id);
    case (id)
      5'd0:    rom_freq_fn = 16'd4032;
      5'd24:   rom_freq_fn = 16'd7268;
      5'd30:   rom_freq_fn = 16'd10279;
      5'd31:   rom_freq_fn = 16'd0;
      default: rom_freq_fn = {3'b000, id, 8'h00};
    endcase
  endfunction

  assign rom_level = rom_level_fn(rom_index);
  assign rom_freq  = rom_freq_fn(rom_freq_id);

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every sample_valid must match the oldest expected sample and
  // fall in the 4th cycle after the sampling edge (edge count + 3).
  always @(negedge clock) begin
    exp_t e;
    if (sample_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sample_out", int'(sample_out), e.value);
        chk("valid_latency", cyc - e.edge_cyc, 3);
      end
    end
    if (tick_overrun) overrun_count++;
  end

  // Pulse a tick; after the sampling edge check the ROM drive for voice 0.
  task automatic start_tick(input bit push, input int exp_out, input int exp_idx,
                            input int exp_fid, input bit scramble);
    exp_t e;
    @(negedge clock);
    if (push) begin
      e.value    = exp_out;
      e.edge_cyc = cyc + 1;
      sb.push_back(e);
      expected_valids++;
    end
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    chk("rom_index_v0", int'(rom_index), exp_idx);
    chk("rom_freq_id_v0", int'(rom_freq_id), exp_fid);
    chk("busy_in_sweep", int'(busy), 1);
    if (scramble) begin
      voice_en = ~voice_en;
      freq_id0 = 5'd5;
      freq_id1 = 5'd5;
      freq_id2 = 5'd5;
    end
  endtask

  task automatic sweep(input int exp_out, input int exp_idx, input int exp_fid,
                       input bit scramble);
    start_tick(1'b1, exp_out, exp_idx, exp_fid, scramble);
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int wrap_out [7] = '{0, 32, 1, 33, 2, 35, 3};
    int wrap_idx [7] = '{0, 160, 321, 481, 642, 803, 963};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick_overrun", int'(tick_overrun), 0);
    chk("rst_rom_index", int'(rom_index), 0);
    chk("rst_rom_freq_id", int'(rom_freq_id), 0);
    reset = 1'b0;

    // Single voice, tone 24: phase0 0 -> 7268, index 113 -> level 30
    voice_en = 3'b001; freq_id0 = 5'd24;
    sweep(0, 0, 24, 1'b0);
    sweep(30, 113, 24, 1'b0);

    // Chord of three tone-24 voices; inputs scrambled mid-sweep on tick 2
    do_reset();
    voice_en = 3'b111; freq_id0 = 5'd24; freq_id1 = 5'd24; freq_id2 = 5'd24;
    sweep(0, 0, 24, 1'b0);
    sweep(90, 113, 24, 1'b1);
    // scrambled inputs (no voices, tone 5) apply now; phase0=14536 -> 227
    sweep(0, 227, 5, 1'b0);
    sweep(0, 0, 5, 1'b0);

    // Full-scale chord: index 63 -> level 63 on all voices -> 189
    do_reset();
    voice_en = 3'b111; freq_id0 = 5'd0; freq_id1 = 5'd0; freq_id2 = 5'd0;
    sweep(0, 0, 0, 1'b0);
    sweep(189, 63, 0, 1'b0);

    // Voices 0 and 2: 30 (index 113) + 32 (index 160)
    do_reset();
    voice_en = 3'b101; freq_id0 = 5'd24; freq_id1 = 5'd7; freq_id2 = 5'd30;
    sweep(0, 0, 24, 1'b0);
    sweep(62, 113, 24, 1'b0);

    // Phase wrap with tone 30: 7*10279 = 71953 -> 6417, index 100 -> 27
    do_reset();
    voice_en = 3'b001; freq_id0 = 5'd30;
    for (int i = 0; i < 7; i++) sweep(wrap_out[i], wrap_idx[i], 30, 1'b0);
    sweep(27, 100, 30, 1'b0);

    // Tone 31 has zero increment: phase holds, voice still summed
    do_reset();
    voice_en = 3'b001; freq_id0 = 5'd24;
    sweep(0, 0, 24, 1'b0);
    freq_id0 = 5'd31;
    sweep(30, 113, 31, 1'b0);
    sweep(30, 113, 31, 1'b0);

    // Disable after 3 ticks clears phase0; re-enable restarts at index 0
    do_reset();
    voice_en = 3'b001; freq_id0 = 5'd24;
    sweep(0, 0, 24, 1'b0);
    sweep(30, 113, 24, 1'b0);
    sweep(35, 227, 24, 1'b0);
    voice_en = 3'b000;
    sweep(0, 340, 24, 1'b0);
    voice_en = 3'b001;
    sweep(0, 0, 24, 1'b0);
    sweep(30, 113, 24, 1'b0);

    // Overrun: second tick two cycles after the first
    do_reset();
    voice_en = 3'b001; freq_id0 = 5'd24;
    start_tick(1'b1, 0, 0, 24, 1'b0);
    sample_tick = 1'b1;               // sampled on the V1 edge
    @(negedge clock);
    sample_tick = 1'b0;
    chk("overrun_pulse", int'(tick_overrun), 1);
    chk("overrun_busy", int'(busy), 1);
    @(negedge clock);
    chk("overrun_one_cycle", int'(tick_overrun), 0);
    repeat (2) @(negedge clock);
    chk("overrun_idle", int'(busy), 0);
    sweep(30, 113, 24, 1'b0);         // phase advanced by one sweep only

    // Reset during V1 aborts the sweep with no sample_valid
    start_tick(1'b0, 0, 227, 24, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_sample_out", int'(sample_out), 0);
    chk("abort_sample_valid", int'(sample_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rom_index", int'(rom_index), 0);
    chk("abort_rom_freq_id", int'(rom_freq_id), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    sweep(0, 0, 24, 1'b0);
    sweep(30, 113, 24, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    chk("valid_count", valid_count, expected_valids);
    chk("overrun_count", overrun_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chord_voice_scheduler.md
CHORD_VOICE_SCHEDULER -- requirements
Module: chord_voice_scheduler

Interface
REQ-001 Parameter BITS, default 6: width of the sine ROM level output.
REQ-002 clock  input  1  system clock; the block uses this single clock domain, all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sample_tick  input  1  one-cycle pulse at the audio sample rate.
REQ-005 voice_en  input  3  per-voice enable, bit k enables voice k.
REQ-006 freq_id0, freq_id1, freq_id2  input  5 each  tone id for voices 0..2.
REQ-007 rom_index  output  11  registered index driven to the shared sine ROM.
REQ-008 rom_freq_id  output  5  registered tone id driven to the shared sine ROM.
REQ-009 rom_level  input  BITS  ROM level, combinational from rom_index.
REQ-010 rom_freq  input  16  ROM phase increment, combinational from rom_freq_id.
REQ-011 sample_out  output  BITS+2  registered sum of enabled voice levels.
REQ-012 sample_valid  output  1  one-cycle strobe, sample_out updated.
REQ-013 busy  output  1  high while a sweep is in progress (any state other than IDLE).
REQ-014 tick_overrun  output  1  one-cycle pulse when sample_tick arrives while busy.

Function
REQ-015 The block SHALL time-share one ROM among three voices.
- Per-voice 16-bit phase accumulator phase_k.
- rom_index = {1'b0, phase_k[15:6]}, always in the range 0..1023.
REQ-016 The FSM SHALL have states IDLE, V0, V1, V2, DONE.
- IDLE -> V0 on sample_tick.
- V0 -> V1 -> V2 -> DONE -> IDLE, unconditionally, one cycle each.
REQ-017 On the edge leaving IDLE, the block SHALL:
- latch voice_en and all three freq_id inputs into shadow registers for the whole sweep;
- clear the accumulator;
- load rom_freq_id/rom_index for voice 0.
REQ-018 In state Vk, the block SHALL sample rom_level and rom_freq for voice k.
- If shadow enable k = 1: acc += rom_level and phase_k += rom_freq, mod 2^16, wrap silently.
- If shadow enable k = 0: acc unchanged and phase_k <= 0, so the note restarts at a zero crossing.
- The ROM outputs for voice k+1 are loaded on the same edge.
REQ-019 In DONE, the block SHALL load sample_out <= acc and assert sample_valid for exactly that one cycle.
- Latency: sample_valid is high during the 4th cycle after the edge that samples sample_tick.
REQ-020 Width of acc and sample_out SHALL be BITS+2 bits.
- Maximum value 3*(2^BITS-1), so no overflow and no saturation logic.
REQ-021 sample_tick seen in any state other than IDLE SHALL NOT restart or extend the sweep, and SHALL pulse tick_overrun for one cycle.
REQ-022 Input changes mid-sweep SHALL NOT affect the current sweep; they take effect at the next tick.
REQ-023 rom_freq_id = 31 (rom_freq = 0) SHALL hold phase_k constant; the voice is still summed if enabled.
REQ-024 When no voice is enabled, the sweep SHALL still run and produce sample_out = 0 with sample_valid.

Reset
REQ-025 Reset SHALL force, asynchronously:
- state IDLE;
- all phase_k, acc, sample_out, rom_index, rom_freq_id and shadow registers to 0;
- sample_valid, busy and tick_overrun to 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no sample_valid.
- The first tick after reset release starts a fresh sweep from phase 0.

Verification (BITS=6, ROM as deployed)
REQ-027 Single voice: voice_en=001, freq_id0=24.
- Tick 1 -> sample_out=0, phase0=7268.
- Tick 2 -> rom_index=113, sample_out=30 (491>>4).
REQ-028 Chord: voice_en=111, all freq_id=24.
- Tick 1 -> 0.
- Tick 2 -> sample_out=90.
- sample_valid exactly 4 cycles after each tick.
REQ-029 Wrap: voice 0 only, freq_id0=30.
- After 7 ticks, phase0=6417 (71953 mod 65536).
- Next sweep drives rom_index=100, sample_out=27 (442>>4).
REQ-030 Overrun: second tick 2 cycles after the first.
- tick_overrun pulses once.
- Exactly one sample_valid, at the original +4 cycle position.
REQ-031 Disable/reset: disable voice 0 after 3 ticks -> phase0=0 after the next sweep. Separately, assert reset during V1 -> outputs 0 immediately, no sample_valid, busy=0.
